// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order core front end.
// The fetch queue entry carries the fetch PC, the returned instruction word
// and the branch predictor's taken flag for that PC.
package ooo_pkg;

  localparam logic [31:0] RST_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch queue: power-of-two circular buffer of fetch_entry_t with an
// occupancy counter. A flush empties the queue on the same edge and wins over
// any push or pop. The head entry reads as all-zero while the queue is empty.
module if_fetch_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write on an accepted push.
  // NOTE: the data array has no reset; the head mux above masks it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo DEPTH; occupancy follows push/pop, flush clears all.
  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC register, one-deep in-flight tracker for the
// single-cycle instruction memory, and a fetch queue toward decode.
// A request is issued only while queued plus in-flight entries leave room in
// the queue, so the queue can never overflow. A flush redirects the PC and
// discards everything queued or in flight.
// Optional feature macro IF_FETCH_BYPASS_EN: a returning response that finds
// the queue empty and decode ready goes straight to decode that cycle.
module if_fetch_unit
  import ooo_pkg::*;
#(
  parameter int          DEPTH  = 4,
  parameter logic [31:0] RST_PC = RST_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] IM_addr,
  output logic        IM_req,
  input  logic [31:0] IM_rdata,
  output logic        DC_ready,
  input  logic [31:0] next_pc,
  input  logic        jump_out,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_pred
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic          infl_valid;
  logic [31:0]   infl_pc;
  logic          infl_pred;

  fetch_entry_t  resp;
  fetch_entry_t  head;
  fetch_entry_t  id_entry;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW:0]   pending;
  logic          issue;
  logic          bypass;
  logic          q_push;
  logic          q_pop;

  // Credit: queued plus in-flight must stay below DEPTH. Gating with rst keeps
  // the strobe low while reset is held and lets the first edge after release
  // issue a request.
  assign pending  = (CW+1)'(q_count) + (CW+1)'(infl_valid);
  assign issue    = rst && (pending < (CW+1)'(DEPTH)) && !flush;
  assign IM_req   = issue;
  assign DC_ready = issue;
  assign IM_addr  = pc;

  assign resp = '{pc: infl_pc, inst: IM_rdata, pred: infl_pred};

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = infl_valid && q_empty && id_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = infl_valid && !flush && !bypass && !q_full;
  assign q_pop  = !q_empty && id_ready;

  // Decode-side view: queue head, the bypassed response, or zeros when idle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    id_entry = '0;
    id_valid = 1'b0;
    if (!q_empty) begin
      id_entry = head;
      id_valid = 1'b1;
    end else if (bypass) begin
      id_entry = resp;
      id_valid = 1'b1;
    end
  end

  assign id_pc   = id_entry.pc;
  assign id_inst = id_entry.inst;
  assign id_pred = id_entry.pred;

  // PC advances to the predictor's next PC on an issue or a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RST_PC;
    end else if (issue || flush) begin
      pc <= next_pc;
    end
  end

  // In-flight tracker: remembers the PC and prediction of the issued request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_valid <= 1'b0;
      infl_pc    <= '0;
      infl_pred  <= 1'b0;
    end else begin
      infl_valid <= issue;
      if (issue) begin
        infl_pc   <= pc;
        infl_pred <= jump_out;
      end
    end
  end

  if_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .wdata (resp),
    .pop   (q_pop),
    .flush (flush),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule
